// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcode/state types and default width for alu_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 64;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIVU = 3'b011,
    OP_REMU = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_XOR  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// Module   : alu_muldiv_iter
// Brief    : Bit-serial shift-add multiplier and restoring divider (divider
//            present only when ALU_DIVIDE_EN is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int              CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  // x: product / partial remainder, y: multiplicand / divisor,
  // z: multiplier / dividend-then-quotient
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_x, r_y, r_z;
  logic [WIDTH-1:0] w_x_nxt, w_y_nxt, w_z_nxt;
  logic             w_go, w_is_div;

`ifdef ALU_DIVIDE_EN
  alu_op_e        r_mode;
  logic [WIDTH:0] w_rem_sh, w_diff;

  assign w_go     = start && (op == OP_MUL || op == OP_DIVU || op == OP_REMU);
  assign w_is_div = (op != OP_MUL);
  assign w_rem_sh = {r_x, r_z[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_y};
`else
  assign w_go     = start && (op == OP_MUL);
  assign w_is_div = 1'b0;
`endif

  always_comb begin
    w_x_nxt = r_x + (r_z[0] ? r_y : '0);
    w_y_nxt = r_y << 1;
    w_z_nxt = r_z >> 1;
`ifdef ALU_DIVIDE_EN
    if (r_mode != OP_MUL) begin
      w_y_nxt = r_y;
      if (!w_diff[WIDTH]) begin
        w_x_nxt = w_diff[WIDTH-1:0];
        w_z_nxt = {r_z[WIDTH-2:0], 1'b1};
      end else begin
        w_x_nxt = w_rem_sh[WIDTH-1:0];
        w_z_nxt = {r_z[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // done and result are taken from the final iteration's next values so the
  // top can register them on the same edge the last bit is processed
  assign done = r_busy && (r_cnt == C_LAST);
`ifdef ALU_DIVIDE_EN
  assign result = (r_mode == OP_DIVU) ? w_z_nxt : w_x_nxt;
`else
  assign result = w_x_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
`ifdef ALU_DIVIDE_EN
      r_mode <= OP_MUL;
`endif
    end else if (w_go) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= w_is_div ? operand_b : operand_a;
      r_z    <= w_is_div ? operand_a : operand_b;
`ifdef ALU_DIVIDE_EN
      r_mode <= op;
`endif
    end else if (r_busy) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
      r_z <= w_z_nxt;
      if (r_cnt == C_LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle valid/ready ALU; DIVU/REMU built only with ALU_DIVIDE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_div0,
  output logic             flag_unsupported
);

  localparam logic [1:0] C_IDLE = IDLE;
  localparam logic [1:0] C_BUSY = BUSY;
  localparam logic [1:0] C_DONE = DONE;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_flag_zero, r_flag_div0, r_flag_unsup;

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_fast_res, w_iter_res;
  logic             w_div0, w_unsup, w_multi, w_accept, w_iter_done;

  assign w_op     = alu_op_e'(op);
  assign w_accept = in_valid && (r_state == C_IDLE);

  always_comb begin
    w_fast_res = '0;
    w_div0     = 1'b0;
    w_unsup    = 1'b0;
    w_multi    = 1'b0;
    case (w_op)
      OP_ADD:  w_fast_res = operand_a + operand_b;
      OP_SUB:  w_fast_res = operand_a - operand_b;
      OP_AND:  w_fast_res = operand_a & operand_b;
      OP_OR:   w_fast_res = operand_a | operand_b;
      OP_XOR:  w_fast_res = operand_a ^ operand_b;
      OP_MUL:  w_multi    = 1'b1;
      OP_DIVU, OP_REMU: begin
`ifdef ALU_DIVIDE_EN
        if (operand_b == '0) begin
          w_div0     = 1'b1;
          w_fast_res = (w_op == OP_DIVU) ? '1 : operand_a;
        end else begin
          w_multi = 1'b1;
        end
`else
        w_unsup = 1'b1;
`endif
      end
      default: w_fast_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (w_accept && w_multi),
    .op        (w_op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .done      (w_iter_done),
    .result    (w_iter_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= C_IDLE;
      r_result     <= '0;
      r_flag_zero  <= 1'b0;
      r_flag_div0  <= 1'b0;
      r_flag_unsup <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: if (w_accept) begin
          r_flag_div0  <= w_div0;
          r_flag_unsup <= w_unsup;
          if (w_multi) begin
            r_state <= C_BUSY;
          end else begin
            r_state     <= C_DONE;
            r_result    <= w_fast_res;
            r_flag_zero <= (w_fast_res == '0);
          end
        end
        C_BUSY: if (w_iter_done) begin
          r_state     <= C_DONE;
          r_result    <= w_iter_res;
          r_flag_zero <= (w_iter_res == '0);
        end
        C_DONE: if (out_ready) r_state <= C_IDLE;
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign in_ready         = (r_state == C_IDLE);
  assign out_valid        = (r_state == C_DONE);
  assign result           = r_result;
  assign flag_zero        = r_flag_zero;
  assign flag_div0        = r_flag_div0;
  assign flag_unsupported = r_flag_unsup;

endmodule

`default_nettype wire
